// File: rtl/day_of_month_counter.sv
// BCD day-of-month counter with month-length decode, load, adjust, clamp and day-of-week.
// All outputs registered; carry pulses for one cycle after a tick wraps the month.
module day_of_month_counter #(
  parameter int UNIT_W   = 4,
  parameter int TEN_W    = 2,
  parameter int MONTH_W  = 4,
  parameter bit ADJ_WRAP = 1'b1,
  parameter int WDAY_RST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               up,
  input  logic               down,
  input  logic [MONTH_W-1:0] month,
  input  logic               leap_year,
  input  logic               load,
  input  logic [UNIT_W-1:0]  load_unit,
  input  logic [TEN_W-1:0]   load_ten,
  input  logic [2:0]         load_wday,
  output logic [UNIT_W-1:0]  day_unit,
  output logic [TEN_W-1:0]   day_ten,
  output logic [2:0]         wday,
  output logic               carry,
  output logic               month_err
);

  localparam int DW = TEN_W + UNIT_W + 4;

  logic              month_ok;
  logic [TEN_W-1:0]  last_ten;
  logic [UNIT_W-1:0] last_unit;
  logic [DW-1:0]     last_bin;
  logic [DW-1:0]     day_bin;
  logic [DW-1:0]     load_bin;
  logic              load_ok;

  logic [UNIT_W-1:0] inc_unit, dec_unit, nxt_unit;
  logic [TEN_W-1:0]  inc_ten, dec_ten, nxt_ten;
  logic [2:0]        wday_inc, nxt_wday;
  logic              nxt_carry;

  assign month_ok = (month >= MONTH_W'(1)) && (month <= MONTH_W'(12));

  // Month length kept in BCD so the clamp/wrap targets need no conversion.
  always_comb begin
    last_ten  = TEN_W'(3);
    last_unit = UNIT_W'(1);
    case (month)
      MONTH_W'(4), MONTH_W'(6), MONTH_W'(9), MONTH_W'(11): begin
        last_ten  = TEN_W'(3);
        last_unit = UNIT_W'(0);
      end
      MONTH_W'(2): begin
        last_ten  = TEN_W'(2);
        last_unit = leap_year ? UNIT_W'(9) : UNIT_W'(8);
      end
      default: begin
        last_ten  = TEN_W'(3);
        last_unit = UNIT_W'(1);
      end
    endcase
  end

  assign last_bin = DW'(last_ten) * DW'(10) + DW'(last_unit);
  assign day_bin  = DW'(day_ten) * DW'(10) + DW'(day_unit);
  assign load_bin = DW'(load_ten) * DW'(10) + DW'(load_unit);
  assign load_ok  = (load_unit <= UNIT_W'(9)) && (load_ten <= TEN_W'(3)) && (load_wday <= 3'd6);

  assign inc_unit = (day_unit >= UNIT_W'(9)) ? UNIT_W'(0) : day_unit + UNIT_W'(1);
  assign inc_ten  = (day_unit >= UNIT_W'(9)) ? day_ten + TEN_W'(1) : day_ten;
  assign dec_unit = (day_unit == UNIT_W'(0)) ? UNIT_W'(9) : day_unit - UNIT_W'(1);
  assign dec_ten  = (day_unit == UNIT_W'(0)) ? day_ten - TEN_W'(1) : day_ten;
  assign wday_inc = (wday >= 3'd6) ? 3'd0 : wday + 3'd1;

  always_comb begin
    nxt_unit  = day_unit;
    nxt_ten   = day_ten;
    nxt_wday  = wday;
    nxt_carry = 1'b0;
    if (month_ok) begin
      if (load) begin
        // A malformed load is dropped entirely, including any coincident tick.
        if (load_ok) begin
          nxt_wday = load_wday;
          if (load_bin == '0) begin
            nxt_ten  = TEN_W'(0);
            nxt_unit = UNIT_W'(1);
          end else if (load_bin > last_bin) begin
            nxt_ten  = last_ten;
            nxt_unit = last_unit;
          end else begin
            nxt_ten  = load_ten;
            nxt_unit = load_unit;
          end
        end
      end else if (tick) begin
        nxt_wday = wday_inc;
        if (day_bin >= last_bin) begin
          nxt_ten   = TEN_W'(0);
          nxt_unit  = UNIT_W'(1);
          nxt_carry = 1'b1;
        end else begin
          nxt_ten  = inc_ten;
          nxt_unit = inc_unit;
        end
      end else if (up && !down) begin
        if (day_bin < last_bin) begin
          nxt_ten  = inc_ten;
          nxt_unit = inc_unit;
        end else if (ADJ_WRAP) begin
          nxt_ten  = TEN_W'(0);
          nxt_unit = UNIT_W'(1);
        end else begin
          nxt_ten  = last_ten;
          nxt_unit = last_unit;
        end
      end else if (down && !up) begin
        if (day_bin > DW'(1)) begin
          nxt_ten  = dec_ten;
          nxt_unit = dec_unit;
        end else if (ADJ_WRAP) begin
          nxt_ten  = last_ten;
          nxt_unit = last_unit;
        end
      end else if (day_bin > last_bin) begin
        nxt_ten  = last_ten;
        nxt_unit = last_unit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_unit  <= UNIT_W'(1);
      day_ten   <= TEN_W'(0);
      wday      <= 3'(WDAY_RST);
      carry     <= 1'b0;
      month_err <= 1'b0;
    end else begin
      day_unit  <= nxt_unit;
      day_ten   <= nxt_ten;
      wday      <= nxt_wday;
      carry     <= nxt_carry;
      month_err <= !month_ok;
    end
  end

endmodule

// File: tb/tb_day_of_month_counter.sv
// Directed bench for day_of_month_counter: one wrapping and one saturating instance share stimulus.
module tb_day_of_month_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, up, down, leap_year, load;
  logic [3:0] month;
  logic [3:0] load_unit;
  logic [1:0] load_ten;
  logic [2:0] load_wday;

  logic [3:0] wu, su;
  logic [1:0] wt, st;
  logic [2:0] ww, sw;
  logic       wc, sc, we, se;

  int vectors = 0;
  int miscompares = 0;
  int exp_wd;

  always #5 clk = ~clk;

  day_of_month_counter #(.ADJ_WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up(up), .down(down),
    .month(month), .leap_year(leap_year), .load(load),
    .load_unit(load_unit), .load_ten(load_ten), .load_wday(load_wday),
    .day_unit(wu), .day_ten(wt), .wday(ww), .carry(wc), .month_err(we)
  );

  day_of_month_counter #(.ADJ_WRAP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up(up), .down(down),
    .month(month), .leap_year(leap_year), .load(load),
    .load_unit(load_unit), .load_ten(load_ten), .load_wday(load_wday),
    .day_unit(su), .day_ten(st), .wday(sw), .carry(sc), .month_err(se)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int n);
    return 32'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [31:0] day_w();
    return 32'({wt, wu});
  endfunction

  function automatic logic [31:0] day_s();
    return 32'({st, su});
  endfunction

  // Advance one edge, then drop the single-cycle strobes.
  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0;
    up   = 1'b0;
    down = 1'b0;
    load = 1'b0;
  endtask

  task automatic ld(input logic [1:0] ten, input logic [3:0] unit, input logic [2:0] wd);
    load      = 1'b1;
    load_ten  = ten;
    load_unit = unit;
    load_wday = wd;
    step();
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0;
    month = 4'd1; leap_year = 1'b0; load_unit = '0; load_ten = '0; load_wday = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_day", day_w(), 32'h01);
    check("rst_wday", 32'(ww), 0);
    check("rst_carry", 32'(wc), 0);
    check("rst_err", 32'(we), 0);
    rst_n = 1'b1;
    step();

    // January: 31 ticks walk 02..31 then wrap with carry
    exp_wd = 0;
    for (int i = 1; i <= 31; i++) begin
      tick = 1'b1;
      step();
      exp_wd = (exp_wd + 1) % 7;
      check("jan_day", day_w(), bcd((i == 31) ? 1 : i + 1));
      check("jan_carry", 32'(wc), (i == 31) ? 32'd1 : 32'd0);
    end
    check("jan_wday", 32'(ww), 32'(exp_wd));
    check("jan_wday_val", 32'(ww), 3);
    check("jan_s_day", day_s(), 32'h01);
    step();
    check("carry_one_cycle", 32'(wc), 0);

    // February, common and leap
    month = 4'd2; leap_year = 1'b0;
    ld(2'd2, 4'd8, 3'd0);
    check("feb_load28", day_w(), 32'h28);
    tick = 1'b1; step();
    check("feb28_wrap", day_w(), 32'h01);
    check("feb28_carry", 32'(wc), 1);
    leap_year = 1'b1;
    ld(2'd2, 4'd8, 3'd0);
    tick = 1'b1; step();
    check("leap_29", day_w(), 32'h29);
    check("leap_29_carry", 32'(wc), 0);
    tick = 1'b1; step();
    check("leap_wrap", day_w(), 32'h01);
    check("leap_wrap_carry", 32'(wc), 1);

    // Clamp on month shrink
    month = 4'd1;
    ld(2'd3, 4'd1, 3'd5);
    check("jan31", day_w(), 32'h31);
    check("load_wday", 32'(ww), 5);
    month = 4'd4; step();
    check("clamp_apr", day_w(), 32'h30);
    check("clamp_carry", 32'(wc), 0);
    leap_year = 1'b0; month = 4'd2; step();
    check("clamp_feb", day_w(), 32'h28);

    // Adjust: wrap vs saturate
    month = 4'd9;
    ld(2'd0, 4'd1, 3'd4);
    down = 1'b1; step();
    check("down_wrap", day_w(), 32'h30);
    check("down_sat", day_s(), 32'h01);
    check("down_carry", 32'(wc), 0);
    check("down_wday", 32'(ww), 4);
    ld(2'd3, 4'd0, 3'd4);
    up = 1'b1; step();
    check("up_wrap", day_w(), 32'h01);
    check("up_sat", day_s(), 32'h30);
    check("up_carry", 32'(wc), 0);
    check("up_wday", 32'(sw), 4);
    ld(2'd1, 4'd0, 3'd4);
    down = 1'b1; step();
    check("down_borrow", day_w(), 32'h09);
    check("down_borrow_s", day_s(), 32'h09);
    ld(2'd1, 4'd9, 3'd4);
    up = 1'b1; step();
    check("up_carry_digit", day_w(), 32'h20);
    up = 1'b1; down = 1'b1; step();
    check("up_down_hold", day_w(), 32'h20);

    // Loads: invalid fields ignored, 00 forced, over-range clamped, load beats tick
    ld(2'd1, 4'd5, 3'd2);
    check("load15", day_w(), 32'h15);
    ld(2'd1, 4'd10, 3'd3);
    check("bad_unit_day", day_w(), 32'h15);
    check("bad_unit_wday", 32'(ww), 2);
    ld(2'd1, 4'd2, 3'd7);
    check("bad_wday_day", day_w(), 32'h15);
    check("bad_wday_wday", 32'(ww), 2);
    ld(2'd0, 4'd0, 3'd1);
    check("load00", day_w(), 32'h01);
    month = 4'd6;
    ld(2'd3, 4'd1, 3'd1);
    check("load31_jun", day_w(), 32'h30);
    tick = 1'b1;
    ld(2'd1, 4'd5, 3'd6);
    check("load_tick_day", day_w(), 32'h15);
    check("load_tick_carry", 32'(wc), 0);
    check("load_tick_wday", 32'(ww), 6);

    // Invalid month freezes everything
    month = 4'd13; tick = 1'b1; step();
    check("m13_err", 32'(we), 1);
    check("m13_day", day_w(), 32'h15);
    check("m13_wday", 32'(ww), 6);
    check("m13_carry", 32'(wc), 0);
    tick = 1'b1; step();
    check("m13_day2", day_w(), 32'h15);
    month = 4'd0; load = 1'b1; load_ten = 2'd0; load_unit = 4'd3; step();
    check("m0_err", 32'(we), 1);
    check("m0_load_ignored", day_w(), 32'h15);
    month = 4'd1; step();
    check("m1_err_clear", 32'(we), 0);

    // Async reset while carry is high
    ld(2'd3, 4'd1, 3'd3);
    tick = 1'b1; step();
    check("pre_rst_carry", 32'(wc), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_carry", 32'(wc), 0);
    check("rst_mid_day", day_w(), 32'h01);
    check("rst_mid_wday", 32'(ww), 0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
